// File: rtl/time_keeper.sv
// Time-of-day counter: 1 Hz prescaler cascading into hh:mm:ss with overwrite and day-rollover pulse.
// Optional alarm compare/flag is built when TIME_KEEPER_ALARM_EN is defined.
module time_keeper #(
  parameter int CLK_FREQ = 100000000,
  parameter int PRESC_W  = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        time_ow,
  input  logic [16:0] time_in,
`ifdef TIME_KEEPER_ALARM_EN
  input  logic        alarm_set,
  input  logic [10:0] alarm_in,
  input  logic        alarm_clr,
  output logic        alarm_flag,
`endif
  output logic [16:0] time_out,
  output logic        sec_tick,
  output logic        day_tick
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ - 1);

  function automatic logic [4:0] clamp_hour(input logic [4:0] h);
    return (h > 5'd23) ? 5'd0 : h;
  endfunction

  function automatic logic [5:0] clamp_min_sec(input logic [5:0] v);
    return (v > 6'd59) ? 6'd0 : v;
  endfunction

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [4:0]         hour_q, hour_d;
  logic [5:0]         min_q, min_d;
  logic [5:0]         sec_q, sec_d;
  logic               sec_tick_q, sec_tick_d;
  logic               day_tick_q, day_tick_d;
  logic               sec_event;

  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;
    sec_event  = 1'b0;

    // Overwrite suppresses any second event that would land on the same edge.
    if (time_ow) begin
      hour_d  = clamp_hour(time_in[16:12]);
      min_d   = clamp_min_sec(time_in[11:6]);
      sec_d   = clamp_min_sec(time_in[5:0]);
      presc_d = '0;
    end else if (run_en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d   = '0;
        sec_event = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end

    if (sec_event) begin
      sec_tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d     = 5'd0;
            day_tick_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign time_out = {hour_q, min_q, sec_q};
  assign sec_tick = sec_tick_q;
  assign day_tick = day_tick_q;

`ifdef TIME_KEEPER_ALARM_EN
  logic [4:0] alarm_hour_q, alarm_hour_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic       alarm_flag_q, alarm_flag_d;

  // The match uses the alarm value held before any same-cycle alarm_set.
  always_comb begin
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_flag_d = alarm_flag_q;
    if (alarm_set) begin
      alarm_hour_d = clamp_hour(alarm_in[10:6]);
      alarm_min_d  = clamp_min_sec(alarm_in[5:0]);
    end
    if (alarm_clr) begin
      alarm_flag_d = 1'b0;
    end
    if (sec_event && ({hour_d, min_d, sec_d} == {alarm_hour_q, alarm_min_q, 6'd0})) begin
      alarm_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_hour_q <= 5'd0;
      alarm_min_q  <= 6'd0;
      alarm_flag_q <= 1'b0;
    end else begin
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_flag_q <= alarm_flag_d;
    end
  end

  assign alarm_flag = alarm_flag_q;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper with CLK_FREQ=4: expectations are queued by cycle number
// and a negedge monitor compares them against the DUT outputs.
module tb_time_keeper;

  localparam int CF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en;
  logic        time_ow;
  logic [16:0] time_in;
  logic [16:0] time_out;
  logic        sec_tick;
  logic        day_tick;
`ifdef TIME_KEEPER_ALARM_EN
  logic        alarm_set;
  logic [10:0] alarm_in;
  logic        alarm_clr;
  logic        alarm_flag;
`endif

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [16:0] t;
    logic        st;
    logic        dt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  time_keeper #(.CLK_FREQ(CF), .PRESC_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_en   (run_en),
    .time_ow  (time_ow),
    .time_in  (time_in),
`ifdef TIME_KEEPER_ALARM_EN
    .alarm_set (alarm_set),
    .alarm_in  (alarm_in),
    .alarm_clr (alarm_clr),
    .alarm_flag(alarm_flag),
`endif
    .time_out (time_out),
    .sec_tick (sec_tick),
    .day_tick (day_tick)
  );

  function automatic logic [16:0] tm(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic push(input int c, input logic [16:0] t, input logic st, input logic dt);
    exp_t e;
    e.cyc = c;
    e.t   = t;
    e.st  = st;
    e.dt  = dt;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      n_vec++;
      if (cur.cyc != cyc || time_out !== cur.t || sec_tick !== cur.st || day_tick !== cur.dt) begin
        n_err++;
        $display("FAIL cycle %0d (due %0d): time_out=%05h sec_tick=%b day_tick=%b, expected %05h %b %b",
                 cyc, cur.cyc, time_out, sec_tick, day_tick, cur.t, cur.st, cur.dt);
      end
    end
  end

  initial begin
    int c;
    rst     = 1'b1;
    run_en  = 1'b0;
    time_ow = 1'b0;
    time_in = '0;
`ifdef TIME_KEEPER_ALARM_EN
    alarm_set = 1'b0;
    alarm_in  = '0;
    alarm_clr = 1'b0;
`endif
    @(negedge clk);
    push(cyc + 1, tm(0, 0, 0), 1'b0, 1'b0);
    @(negedge clk);

    // Free run from reset: tick every 4th cycle, 00:00:05 after 20 cycles.
    c = cyc;
    for (int k = 1; k <= 20; k++) push(c + k, tm(0, 0, k / 4), (k % 4) == 0, 1'b0);
    rst    = 1'b0;
    run_en = 1'b1;
    repeat (20) @(negedge clk);

    // Day rollover.
    c = cyc;
    time_ow = 1'b1;
    time_in = tm(23, 59, 58);
    push(c + 1,  tm(23, 59, 58), 1'b0, 1'b0);
    push(c + 4,  tm(23, 59, 58), 1'b0, 1'b0);
    push(c + 5,  tm(23, 59, 59), 1'b1, 1'b0);
    push(c + 6,  tm(23, 59, 59), 1'b0, 1'b0);
    push(c + 8,  tm(23, 59, 59), 1'b0, 1'b0);
    push(c + 9,  tm(0, 0, 0),    1'b1, 1'b1);
    push(c + 10, tm(0, 0, 0),    1'b0, 1'b0);
    @(negedge clk);
    time_ow = 1'b0;
    repeat (9) @(negedge clk);

    // Clamped overwrite, held two cycles, then first tick 4 cycles after release.
    c = cyc;
    time_ow = 1'b1;
    time_in = {5'd25, 6'd60, 6'd30};
    push(c + 1, tm(0, 0, 30),  1'b0, 1'b0);
    push(c + 2, tm(0, 10, 0),  1'b0, 1'b0);
    push(c + 5, tm(0, 10, 0),  1'b0, 1'b0);
    push(c + 6, tm(0, 10, 1),  1'b1, 1'b0);
    push(c + 7, tm(0, 10, 1),  1'b0, 1'b0);
    push(c + 8, tm(0, 10, 1),  1'b0, 1'b0);
    @(negedge clk);
    time_in = {5'd24, 6'd10, 6'd63};
    @(negedge clk);
    time_ow = 1'b0;
    repeat (6) @(negedge clk);

    // Freeze with prescaler at 2 for 10 cycles; resume ticks 2 cycles later.
    c = cyc;
    run_en = 1'b0;
    for (int k = 1; k <= 11; k++) push(c + k, tm(0, 10, 1), 1'b0, 1'b0);
    push(c + 12, tm(0, 10, 2), 1'b1, 1'b0);
    for (int k = 13; k <= 15; k++) push(c + k, tm(0, 10, 2), 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    run_en = 1'b1;
    repeat (5) @(negedge clk);

    // Overwrite on the edge a second event was due: load wins, no tick.
    c = cyc;
    time_ow = 1'b1;
    time_in = tm(12, 34, 55);
    push(c + 1, tm(12, 34, 55), 1'b0, 1'b0);
    push(c + 4, tm(12, 34, 55), 1'b0, 1'b0);
    push(c + 5, tm(12, 34, 56), 1'b1, 1'b0);
    push(c + 7, tm(12, 34, 56), 1'b0, 1'b0);
    @(negedge clk);
    time_ow = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-second, then the partial second must be discarded.
    #2 rst = 1'b1;
    #1 check("async_rst", {13'd0, time_out, sec_tick, day_tick}, 32'd0);
    push(cyc + 1, tm(0, 0, 0), 1'b0, 1'b0);
    @(negedge clk);
    c = cyc;
    for (int k = 1; k <= 3; k++) push(c + k, tm(0, 0, 0), 1'b0, 1'b0);
    push(c + 4, tm(0, 0, 1), 1'b1, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

`ifdef TIME_KEEPER_ALARM_EN
    alarm_set = 1'b1;
    alarm_in  = {5'd7, 6'd30};
    time_ow   = 1'b1;
    time_in   = tm(7, 29, 59);
    @(negedge clk);
    alarm_set = 1'b0;
    time_ow   = 1'b0;
    check("alarm_idle", {31'd0, alarm_flag}, 32'd0);
    repeat (4) @(negedge clk);
    check("alarm_time", {15'd0, time_out}, {15'd0, tm(7, 30, 0)});
    check("alarm_set_flag", {31'd0, alarm_flag}, 32'd1);
    repeat (4) @(negedge clk);
    check("alarm_held", {31'd0, alarm_flag}, 32'd1);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    check("alarm_clr", {31'd0, alarm_flag}, 32'd0);
    time_ow = 1'b1;
    time_in = tm(7, 30, 0);
    @(negedge clk);
    time_ow = 1'b0;
    check("alarm_ow_time", {15'd0, time_out}, {15'd0, tm(7, 30, 0)});
    check("alarm_ow_noflag", {31'd0, alarm_flag}, 32'd0);
    repeat (4) @(negedge clk);
    check("alarm_after_ow", {31'd0, alarm_flag}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Real-time-of-day counter that produces the 17-bit time bus hhhhh_mmmmmm_ssssss, which the calendar block consumes as its hour input.
- Derives a 1 Hz enable from the system clock with a prescaler, then cascades seconds, minutes and hours.
- Supports a synchronous time overwrite and a day-rollover pulse.
- Sits between the board clock and the calendar / seven-segment display path.

Parameters:
- CLK_FREQ, 100000000, system clock cycles per second; legal range >= 1.
- PRESC_W, 27, prescaler counter width; must satisfy 2^PRESC_W >= CLK_FREQ.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- run_en  input  1  1 = time advances; 0 = prescaler and time frozen.
- time_ow  input  1  synchronous time overwrite strobe.
- time_in  input  17  {hour[4:0], minute[5:0], second[5:0]} load value.
- time_out  output  17  {hour, minute, second}, registered.
- sec_tick  output  1  one-cycle pulse, coincident with each second update.
- day_tick  output  1  one-cycle pulse, coincident with the 23:59:59 -> 00:00:00 update.

Behaviour:
- Reset (async, rst=1): prescaler=0, time_out=17'd0 (00:00:00), sec_tick=0, day_tick=0. Outputs remain at these values while rst is high. Reset mid-count discards the partial second.
- Prescaler: counts 0..CLK_FREQ-1 while run_en=1 and time_ow=0.
  - At the edge where prescaler==CLK_FREQ-1, the prescaler wraps to 0 and a "second event" occurs on that same edge.
  - CLK_FREQ=1: every enabled cycle is a second event.
- Second event, all fields updated on the same edge:
  - sec_tick <= 1.
  - second <= second==59 ? 0 : second+1.
  - If second==59: minute <= minute==59 ? 0 : minute+1.
  - If second==59 and minute==59: hour <= hour==23 ? 0 : hour+1.
  - If the time was 23:59:59: day_tick <= 1.
- sec_tick and day_tick are 0 in every other cycle. The minimum period is CLK_FREQ cycles.
- run_en=0: prescaler, time_out and pulses hold or clear as follows: counters hold, pulses 0. Re-asserting run_en resumes from the held prescaler value; no partial-second reset.
- time_ow=1 (synchronous, highest priority after rst):
  - Loads each field of time_in.
  - Each out-of-range field is independently replaced by 0: hour>23 -> 0, minute>59 -> 0, second>59 -> 0.
  - Prescaler <= 0; sec_tick and day_tick <= 0, even if a second event would have occurred.
  - Held high: time_out continuously follows time_in (clamped) and no ticks occur.
  - After release, the first second event occurs CLK_FREQ enabled cycles later.
- time_ow is effective regardless of run_en.
- Latency: time_in -> time_out is 1 clock.
- Arithmetic: all field increments stay within field width; no field ever holds an out-of-range value.
- Downstream contract: hour goes 23 -> 0 only through rollover or overwrite. day_tick marks rollover only.

Optional Feature:
- Macro: TIME_KEEPER_ALARM_EN.
- When defined, four extra ports exist:
  - alarm_set input 1
  - alarm_in input 11 ({hour, minute})
  - alarm_clr input 1
  - alarm_flag output 1
- Alarm register:
  - Reset value 11'd0.
  - On alarm_set=1, loads alarm_in with the same clamping rules as time_ow.
  - alarm_set has priority over a same-cycle match check, which uses the old value.
- alarm_flag:
  - Sets (registered) on a second event whose new time equals {alarm_hour, alarm_minute, 0}.
  - Never sets on overwrite.
  - Holds until alarm_clr=1, which clears it next edge.
  - If alarm_clr and a match occur in the same cycle, set wins.
  - Reset value 0.
- When not defined: the ports are absent, no alarm logic is present, and behaviour is otherwise identical.

Test Plan:
- CLK_FREQ=4, rst released, run_en=1, 20 cycles -> sec_tick pulses every 4th cycle; time_out reaches 00:00:05 after 20 cycles; day_tick never high.
- time_ow with 23:59:58, then run 8 cycles -> 23:59:59, then 00:00:00 with sec_tick=1 and day_tick=1 in the same cycle only.
- time_ow with hour=25, minute=60, second=30 -> time_out=00:00:30 after 1 clock; first sec_tick exactly 4 enabled cycles after time_ow falls.
- Deassert run_en for 10 cycles at prescaler=2 -> time_out frozen and no ticks; after re-enable, next sec_tick after 2 cycles.
- Assert rst asynchronously mid-second at 12:34:56 -> time_out=0 and pulses 0 immediately, without waiting for a clk edge; time_ow and second event in the same cycle -> load wins, no tick.
- TIME_KEEPER_ALARM_EN: alarm_set 07:30, overwrite 07:29:59, run -> alarm_flag=1 at 07:30:00 and held; alarm_clr -> 0; overwrite to 07:30:00 -> flag stays 0.
